// File: rtl/gpio_avl_ctrl.sv
// Avalon-MM GPIO controller.
// Output register, per-bit synchronised and debounced inputs, edge capture
// with write-1-to-clear, and a maskable registered level interrupt.
// Word map: 0 IN (ro), 1 OUT (rw), 2 MASK (rw), 3 EDGE_CAP (read / W1C).
module gpio_avl_ctrl #(
  parameter int          IN_W       = 8,
  parameter int          OUT_W      = 8,
  parameter int          DEB_CYCLES = 50000,
  parameter int          EDGE_MODE  = 0,
  parameter logic [31:0] OUT_RESET  = 32'h0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             AVL_CS,
  input  logic             AVL_READ,
  input  logic             AVL_WRITE,
  input  logic [1:0]       AVL_ADDR,
  input  logic [31:0]      AVL_WRITEDATA,
  output logic [31:0]      AVL_READDATA,
  output logic             IRQ,
  input  logic [IN_W-1:0]  PIN_IN,
  output logic [OUT_W-1:0] PIN_OUT
);

  localparam int              CW        = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [OUT_W-1:0] OUT_RST_V = OUT_RESET[OUT_W-1:0];

  logic            wr_en;
  logic            rd_en;
  logic [IN_W-1:0] sync_p0;
  logic [IN_W-1:0] sync_p1;
  logic [IN_W-1:0] deb;
  logic [IN_W-1:0] deb_nxt;
  logic [IN_W-1:0] rise;
  logic [IN_W-1:0] fall;
  logic [IN_W-1:0] edge_set;
  logic [IN_W-1:0] edge_clr;
  logic [IN_W-1:0] edge_cap;
  logic [IN_W-1:0] mask;
  logic [31:0]     rd_mux;
  logic            wdata_unused;

  assign wr_en = AVL_CS & AVL_WRITE;
  assign rd_en = AVL_CS & AVL_READ;

  // Only the low IN_W/OUT_W write-data bits are stored anywhere.
  assign wdata_unused = ^AVL_WRITEDATA;

  // Two-flop synchroniser for the raw asynchronous pins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= PIN_IN;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce stage: one stability counter per input bit ----
  for (genvar i = 0; i < IN_W; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    assign differ     = sync_p1[i] ^ deb[i];
    assign accept     = differ && (cnt == CNT_LAST);
    assign deb_nxt[i] = accept ? sync_p1[i] : deb[i];

    // Count consecutive clocks where the synced bit disagrees with the
    // debounced bit; any agreement or an accepted change restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        cnt <= '0;
      end else if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Debounced input value, updated when a bit has been stable long enough.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      deb <= '0;
    end else begin
      deb <= deb_nxt;
    end
  end

  // ---- edge detect stage: transitions of the debounced value ----
  assign rise = deb_nxt & ~deb;
  assign fall = deb & ~deb_nxt;

  // Select which debounced transitions are recorded.
  always_comb begin
    edge_set = rise;
    case (EDGE_MODE)
      1:       edge_set = fall;
      2:       edge_set = rise | fall;
      default: edge_set = rise;
    endcase
  end

  assign edge_clr = (wr_en && (AVL_ADDR == 2'd3)) ? AVL_WRITEDATA[IN_W-1:0] : '0;

  // Sticky edge flags; a new edge overrides a same-cycle W1C of that bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
    end
  end

  // Writable output and mask registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PIN_OUT <= OUT_RST_V;
      mask    <= '0;
    end else if (wr_en) begin
      if (AVL_ADDR == 2'd1) begin
        PIN_OUT <= AVL_WRITEDATA[OUT_W-1:0];
      end
      if (AVL_ADDR == 2'd2) begin
        mask <= AVL_WRITEDATA[IN_W-1:0];
      end
    end
  end

  // Registered level interrupt from the currently stored flags and mask.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= |(edge_cap & mask);
    end
  end

  // ---- bus read stage: zero-extended register select ----
  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      2'd0:    rd_mux[IN_W-1:0]  = deb;
      2'd1:    rd_mux[OUT_W-1:0] = PIN_OUT;
      2'd2:    rd_mux[IN_W-1:0]  = mask;
      default: rd_mux[IN_W-1:0]  = edge_cap;
    endcase
  end

  // Read data is captured on the read strobe and held until the next read;
  // it samples pre-write register contents when a write hits the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AVL_READDATA <= '0;
    end else if (rd_en) begin
      AVL_READDATA <= rd_mux;
    end
  end

endmodule

// File: doc/gpio_avl_ctrl.md
Name: gpio_avl_ctrl

Overview:
Parametrised Avalon-MM slave GPIO controller. It is the next-generation replacement for the fixed 8-bit LED/KEY/SW parallel ports in the Nios II SoC top level. The block provides configurable-width output and input ports, per-bit input synchronisation and debounce, per-bit edge capture with a configurable edge mode, and a maskable level interrupt to the Nios II. It sits between the SoC Avalon fabric and the board LEDs, keys and switches.

Parameters:
IN_W, 8, number of input pins (1..32)
OUT_W, 8, number of output pins (1..32)
DEB_CYCLES, 50000, consecutive stable clocks required to accept an input change (>=2; 1 ms at 50 MHz)
EDGE_MODE, 0, edge-capture mode: 0 = rising, 1 = falling, 2 = both
OUT_RESET, 0, reset value of the output register (OUT_W bits)

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
AVL_CS  input  1  chip select
AVL_READ  input  1  read strobe, qualified by AVL_CS
AVL_WRITE  input  1  write strobe, qualified by AVL_CS
AVL_ADDR  input  2  word address
AVL_WRITEDATA  input  32  write data
AVL_READDATA  output  32  read data, registered
IRQ  output  1  level interrupt
PIN_IN  input  IN_W  raw asynchronous pins (keys/switches)
PIN_OUT  output  OUT_W  output pins (LEDs), registered

Behaviour:
- One clock. Reset is asynchronous and active-high. All state clears on Reset assertion, with no clock required.
- Reset values:
  - PIN_OUT = OUT_RESET
  - AVL_READDATA = 0
  - IRQ = 0
  - sync flops, debounced value, counters, EDGE_CAP and MASK = 0
- Register map (word addresses):
  - 0 IN: read-only debounced inputs, zero-extended. Writes are ignored.
  - 1 OUT: read/write output register. A write loads WRITEDATA[OUT_W-1:0]; PIN_OUT changes the cycle after the write.
  - 2 MASK: read/write, IN_W bits.
  - 3 EDGE_CAP: read gives the captured edges. Write is write-1-to-clear per bit.
- Bus timing:
  - Read latency is exactly 1 cycle. AVL_READDATA is valid the cycle after AVL_CS && AVL_READ and holds until the next read.
  - Writes take effect on the strobe edge. No wait states.
  - Unused upper bits read 0.
  - Simultaneous READ and WRITE: the write is performed; the read returns the pre-write value.
- Synchroniser: each PIN_IN bit passes through 2 flops before the debouncer.
- Debounce, per bit independently:
  - Each bit has a counter of width clog2(DEB_CYCLES+1).
  - If the synced bit equals the debounced bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, the debounced bit takes the synced value and the counter clears.
  - Any glitch shorter than DEB_CYCLES clocks never reaches the debounced bit.
  - Total latency from a pin change to the IN register is 2 + DEB_CYCLES clocks.
- Edge capture: a debounced-bit transition matching EDGE_MODE sets EDGE_CAP[i]. The bit is sticky until cleared by W1C.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- IRQ = |(EDGE_CAP & MASK), registered, so it asserts 1 cycle after the enabling condition.
  - Writing MASK or clearing EDGE_CAP deasserts IRQ on the following cycle.
- Reset mid-debounce discards partial counts. After reset the debounced value is 0, so a pin held high at reset produces a rising edge after 2 + DEB_CYCLES clocks.

Test Plan:
- Reset and register defaults: DEB_CYCLES=4, OUT_RESET=8'hA5. Assert Reset with no clock edge -> PIN_OUT=8'hA5 and IRQ=0 immediately. After release, reads of addr 0/2/3 return 0 and addr 1 returns 32'h000000A5, each with 1-cycle latency.
- Output write and readback: write addr 1 = 32'hFFFF_FF3C -> PIN_OUT=8'h3C the next cycle. Read addr 1 returns 32'h0000_003C. A write to addr 0 leaves the IN register unchanged.
- Debounce:
  - PIN_IN[0] high for 3 clocks then low -> IN stays 0 and EDGE_CAP stays 0.
  - PIN_IN[0] held high -> IN[0]=1 exactly 6 clocks after the pin change.
- Edge capture and IRQ (EDGE_MODE=0):
  - With MASK=8'h01, a debounced rise on bit 0 gives EDGE_CAP=1 and IRQ=1 one cycle later. A falling edge does not set EDGE_CAP.
  - Write addr 3 = 1 -> IRQ=0 on the next cycle.
- Collision and mask: a W1C of bit 0 in the same cycle as a new rise on bit 0 leaves EDGE_CAP[0]=1. With EDGE_CAP=8'h02 and MASK=8'h01, IRQ=0; then writing MASK=8'h03 gives IRQ=1.
- Mode and width sweep: with IN_W=32, OUT_W=1, EDGE_MODE=2, toggle bit 31 up then down -> EDGE_CAP[31] sets on each edge (clear between edges). Reads of addr 1 return 32'h1 or 32'h0.
